// File: rtl/polar64_crc16_codec.sv
// rtl/polar64_crc16_codec.sv - (64,24) polar encoder and bounded-distance decoder with CRC-16 outer code
// Encoder and decoder run independently on one clock; the decoder corrects up to 3 bit errors.
module polar64_crc16_codec #(
   parameter int DEC_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enc_start,
   input  logic [23:0] data_in,
   output logic        enc_done,
   output logic [63:0] codeword,
   input  logic        dec_start,
   input  logic [63:0] rx,
   output logic        dec_done,
   output logic [23:0] data_out,
   output logic        valid
);

   function automatic logic [15:0] crc16(input logic [23:0] d);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 23; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic is_info(input int i);
      return ($countones(i[5:0]) >= 3) && (i != 7) && (i != 11);
   endfunction

   function automatic logic [63:0] frozen_mask();
      logic [63:0] f;
      for (int i = 0; i < 64; i++) f[i] = !is_info(i);
      return f;
   endfunction

   localparam logic [63:0] FROZEN   = frozen_mask();
   localparam logic [3:0]  CNT_LAST = 4'(DEC_LAT - 1);

   function automatic logic [63:0] xform(input logic [63:0] v);
      logic [63:0] x;
      x = v;
      for (int s = 0; s < 6; s++)
         for (int i = 0; i < 64; i++)
            if (((i >> s) & 1) == 0) x[i] = x[i] ^ x[i + (1 << s)];
      return x;
   endfunction

   function automatic logic [63:0] place(input logic [39:0] m);
      logic [63:0] u;
      int k;
      u = '0;
      k = 0;
      for (int i = 0; i < 64; i++)
         if (is_info(i)) begin
            u[i] = m[k];
            k++;
         end
      return u;
   endfunction

   function automatic logic [39:0] extract(input logic [63:0] u);
      logic [39:0] m;
      int k;
      m = '0;
      k = 0;
      for (int i = 0; i < 64; i++)
         if (is_info(i)) begin
            m[k] = u[i];
            k++;
         end
      return m;
   endfunction

   // Frozen-bit syndrome of one error at p: frozen row j sees it iff bits(j) is a subset of bits(p)
   function automatic logic [63:0] hcol(input logic [5:0] p);
      logic [63:0] h;
      for (int j = 0; j < 64; j++)
         h[j] = !is_info(j) && ((6'(j) & p) == 6'(j));
      return h;
   endfunction

   // Residual of weight 0 or 2. Singleton rows give p^q; with t a differing bit,
   // the pair rows {a,t} read out the error position that has bit t set.
   function automatic logic [64:0] solve2(input logic [63:0] r);
      logic [5:0]  d, p, q;
      logic [63:0] pat;
      logic        ok;
      logic [64:0] res;
      int          t;
      d = {r[32], r[16], r[8], r[4], r[2], r[1]};
      t = 0;
      for (int b = 5; b >= 0; b--) if (d[b]) t = b;
      q = '0;
      for (int a = 0; a < 6; a++) q[a] = (a == t) ? 1'b1 : r[(1 << a) | (1 << t)];
      p   = q ^ d;
      pat = (64'd1 << p) | (64'd1 << q);
      ok  = !r[0] && (d != '0) && ((hcol(p) ^ hcol(q)) == r);
      if (r == '0) res = {1'b1, 64'd0};
      else         res = {ok, pat};
      return res;
   endfunction

   typedef enum logic [1:0] {ENC_IDLE, ENC_CRC, ENC_XFORM} enc_state_e;

   enc_state_e  enc_state_q, enc_state_d;
   logic [23:0] enc_data_q, enc_data_d;
   logic [39:0] msg_q, msg_d;
   logic [63:0] codeword_q, codeword_d;
   logic        enc_done_q, enc_done_d;

   always_comb begin
      enc_state_d = enc_state_q;
      enc_data_d  = enc_data_q;
      msg_d       = msg_q;
      codeword_d  = codeword_q;
      enc_done_d  = 1'b0;
      case (enc_state_q)
         ENC_IDLE: if (enc_start) begin
            enc_data_d  = data_in;
            enc_state_d = ENC_CRC;
         end
         ENC_CRC: begin
            msg_d       = {enc_data_q, crc16(enc_data_q)};
            enc_state_d = ENC_XFORM;
         end
         ENC_XFORM: begin
            codeword_d  = xform(place(msg_q));
            enc_done_d  = 1'b1;
            enc_state_d = ENC_IDLE;
         end
         default: enc_state_d = ENC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_state_q <= ENC_IDLE;
         enc_data_q  <= '0;
         msg_q       <= '0;
         codeword_q  <= '0;
         enc_done_q  <= 1'b0;
      end else begin
         enc_state_q <= enc_state_d;
         enc_data_q  <= enc_data_d;
         msg_q       <= msg_d;
         codeword_q  <= codeword_d;
         enc_done_q  <= enc_done_d;
      end
   end

   logic        dec_busy_q, dec_done_q, valid_q, hit_q, hit_d;
   logic [3:0]  dec_cnt_q;
   logic [63:0] rx_q, syn_q, e_q, e_d;
   logic [23:0] data_out_q;
   logic [39:0] dec_m;
   logic        res_valid;

   // Candidate c guesses one error position (c == 64: none); the remainder is solved as weight 0 or 2.
   // With dmin = 8 at most one pattern of weight <= 3 fits, so all hits agree on e.
   always_comb begin
      logic [63:0] r, base;
      logic [64:0] sol;
      r     = '0;
      base  = '0;
      sol   = '0;
      e_d   = '0;
      hit_d = 1'b0;
      for (int c = 0; c <= 64; c++) begin
         base = (c == 64) ? 64'd0 : (64'd1 << c);
         r    = (c == 64) ? syn_q : (syn_q ^ hcol(6'(c)));
         sol  = solve2(r);
         if (sol[64]) begin
            e_d   = e_d | (base ^ sol[63:0]);
            hit_d = 1'b1;
         end
      end
   end

   assign dec_m     = extract(xform(rx_q ^ e_q));
   assign res_valid = hit_q && (crc16(dec_m[39:16]) == dec_m[15:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_busy_q <= 1'b0;
         dec_cnt_q  <= '0;
         rx_q       <= '0;
         syn_q      <= '0;
         e_q        <= '0;
         hit_q      <= 1'b0;
         dec_done_q <= 1'b0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         dec_done_q <= 1'b0;
         if (!dec_busy_q) begin
            if (dec_start) begin
               dec_busy_q <= 1'b1;
               dec_cnt_q  <= '0;
               rx_q       <= rx;
            end
         end else begin
            dec_cnt_q <= dec_cnt_q + 4'd1;
            if (dec_cnt_q == 4'd0) syn_q <= xform(rx_q) & FROZEN;
            if (dec_cnt_q == 4'd1) begin
               e_q   <= e_d;
               hit_q <= hit_d;
            end
            if (dec_cnt_q == CNT_LAST) begin
               dec_busy_q <= 1'b0;
               dec_done_q <= 1'b1;
               data_out_q <= res_valid ? dec_m[39:16] : 24'd0;
               valid_q    <= res_valid;
            end
         end
      end
   end

   assign enc_done = enc_done_q;
   assign codeword = codeword_q;
   assign dec_done = dec_done_q;
   assign data_out = data_out_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_polar64_crc16_codec.sv
// tb/tb_polar64_crc16_codec.sv - self-checking bench for polar64_crc16_codec
// Reference uses CRC by polynomial division and the direct subset-sum transform.
module tb_polar64_crc16_codec;
   localparam int DEC_LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enc_start = 1'b0;
   logic [23:0] data_in = '0;
   logic        enc_done;
   logic [63:0] codeword;
   logic        dec_start = 1'b0;
   logic [63:0] rx = '0;
   logic        dec_done;
   logic [23:0] data_out;
   logic        valid;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   polar64_crc16_codec #(.DEC_LAT(DEC_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .enc_start(enc_start), .data_in(data_in), .enc_done(enc_done), .codeword(codeword),
      .dec_start(dec_start), .rx(rx), .dec_done(dec_done), .data_out(data_out), .valid(valid)
   );

   // Init 0xFFFF folds into the first 16 message bits; then plain division of M*x^16.
   function automatic logic [15:0] ref_crc(input logic [23:0] d);
      logic [39:0] v;
      v = {d ^ 24'hFFFF00, 16'h0000};
      for (int b = 39; b >= 16; b--)
         if (v[b]) v = v ^ (40'h11021 << (b - 16));
      return v[15:0];
   endfunction

   function automatic logic [63:0] ref_encode(input logic [23:0] d);
      logic [39:0] m;
      logic [63:0] u, x;
      int k;
      m = {d, ref_crc(d)};
      u = '0;
      k = 0;
      for (int j = 0; j < 64; j++)
         if ($countones(j) >= 3 && j != 7 && j != 11) begin
            u[j] = m[k];
            k++;
         end
      for (int i = 0; i < 64; i++) begin
         x[i] = 1'b0;
         for (int j = 0; j < 64; j++)
            if ((i & j) == i) x[i] = x[i] ^ u[j];
      end
      return x;
   endfunction

   task automatic run_encode(input logic [23:0] d, output logic [2:0] dn, output logic [63:0] cw);
      @(negedge clk); enc_start = 1'b1; data_in = d;
      @(negedge clk); enc_start = 1'b0;
      @(negedge clk); dn[2] = enc_done;
      @(negedge clk); dn[1] = enc_done; cw = codeword;
      @(negedge clk); dn[0] = enc_done;
   endtask

   task automatic run_decode(input logic [63:0] r, output int lat, output logic [23:0] dout,
                             output logic v, output logic single);
      @(negedge clk); dec_start = 1'b1; rx = r;
      @(negedge clk); dec_start = 1'b0; lat = 0;
      while (dec_done !== 1'b1 && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      dout = data_out;
      v    = valid;
      @(negedge clk); single = (dec_done === 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({enc_done, dec_done, valid} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got=%b exp=000", {enc_done, dec_done, valid});
      end
      checks++;
      if (codeword !== 64'd0) begin errors++; $display("FAIL reset_codeword got=%h exp=0", codeword); end
      checks++;
      if (data_out !== 24'd0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_encode();
      logic [23:0] d;
      logic [63:0] cw, exp_cw;
      logic [2:0]  dn;
      for (int n = 0; n < 100; n++) begin
         d = (n == 0) ? 24'h000000 : (n == 1) ? 24'hFFFFFF : 24'($urandom);
         exp_cw = ref_encode(d);
         run_encode(d, dn, cw);
         checks++;
         if (cw !== exp_cw) begin
            errors++; $display("FAIL enc_codeword data=%h got=%h exp=%h", d, cw, exp_cw);
         end
         checks++;
         if (dn !== 3'b010) begin errors++; $display("FAIL enc_timing data=%h got=%b exp=010", d, dn); end
      end
   endtask

   task automatic test_decode_clean();
      int lat;
      logic [23:0] dout;
      logic v, single;
      run_decode(ref_encode(24'h13579B), lat, dout, v, single);
      checks++;
      if (lat !== DEC_LAT) begin errors++; $display("FAIL dec_clean_latency got=%0d exp=%0d", lat, DEC_LAT); end
      checks++;
      if ({v, dout} !== {1'b1, 24'h13579B}) begin
         errors++; $display("FAIL dec_clean_result got=%b/%h exp=1/13579b", v, dout);
      end
      checks++;
      if (!single) begin errors++; $display("FAIL dec_clean_pulse got=2+ cycles exp=1 cycle"); end
   endtask

   task automatic test_decode_reject();
      logic [63:0] cw, mask;
      int lat;
      logic [23:0] dout;
      logic v, single;
      cw = ref_encode(24'h13579B);
      for (int n = 0; n < 1000; n++) begin
         mask = '0;
         while ($countones(mask) < 4) mask[$urandom_range(63, 0)] = 1'b1;
         run_decode(cw ^ mask, lat, dout, v, single);
         checks++;
         if ({v, dout} !== 25'd0 || lat !== DEC_LAT) begin
            errors++; $display("FAIL dec_reject mask=%h got=%b/%h lat=%0d exp=0/000000 lat=%0d",
                               mask, v, dout, lat, DEC_LAT);
         end
      end
   endtask

   task automatic test_decode_errors();
      logic [63:0] cw, mask;
      int lat, w;
      logic [23:0] dout;
      logic v, single;
      cw = ref_encode(24'h13579B);
      for (int n = 0; n < 30; n++) begin
         w = 1 + n % 3;
         mask = '0;
         if (n < 3) mask[0] = 1'b1;
         else if (n < 6) mask[63] = 1'b1;
         else if (n < 9) begin mask[0] = 1'b1; mask[63] = 1'b1; end
         while ($countones(mask) < w) mask[$urandom_range(63, 0)] = 1'b1;
         run_decode(cw ^ mask, lat, dout, v, single);
         checks++;
         if ({v, dout} !== {1'b1, 24'h13579B}) begin
            errors++; $display("FAIL dec_correct mask=%h got=%b/%h exp=1/13579b", mask, v, dout);
         end
         checks++;
         if (lat !== DEC_LAT || !single) begin
            errors++; $display("FAIL dec_correct_timing mask=%h lat=%0d single=%b exp lat=%0d single=1",
                               mask, lat, single, DEC_LAT);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_cw;
      int pulses;
      exp_cw = ref_encode(24'hA5C31E);
      pulses = 0;
      @(negedge clk); enc_start = 1'b1; data_in = 24'hA5C31E;
      @(negedge clk); data_in = 24'h5A3CE1;
      @(negedge clk); enc_start = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (enc_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
      checks++;
      if (codeword !== exp_cw) begin errors++; $display("FAIL b2b_codeword got=%h exp=%h", codeword, exp_cw); end
   endtask

   task automatic test_reset_abort();
      logic [63:0] cw, exp_cw;
      logic [2:0]  dn;
      int pulses;
      pulses = 0;
      @(negedge clk); enc_start = 1'b1; data_in = 24'h0F1E2D;
      @(negedge clk); enc_start = 1'b0; rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (enc_done === 1'b1) pulses++;
      end
      checks++;
      if ({codeword, data_out, valid, dec_done} !== 90'd0) begin
         errors++; $display("FAIL abort_outputs got cw=%h data=%h valid=%b exp=0", codeword, data_out, valid);
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (enc_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d pulses exp=0", pulses); end
      exp_cw = ref_encode(24'h2468AC);
      run_encode(24'h2468AC, dn, cw);
      checks++;
      if (dn !== 3'b010 || cw !== exp_cw) begin
         errors++; $display("FAIL abort_reencode timing=%b cw=%h exp 010 %h", dn, cw, exp_cw);
      end
   endtask

   initial begin
      test_reset();
      test_encode();
      test_decode_clean();
      test_decode_reject();
      test_decode_errors();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
